// File: rtl/pixel_ram_arbiter.sv
// Arbitrates a single-port pixel RAM between the scan read path (absolute
// priority, front buffer) and a req/ack host port (back buffer), with
// frame-synchronous front/back buffer swapping.
module pixel_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 24
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic                  scan_valid,
  output logic [DATA_WIDTH-1:0] scan_data,
  input  logic                  frame_end,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  host_swap,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  front_buffer,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } host_state_e;

  host_state_e state_q, state_d;
  logic        host_ack_q, host_ack_d;
  logic        scan_valid_q, scan_valid_d;
  logic        swap_pending_q, swap_pending_d;
  logic        swap_done_q, swap_done_d;
  logic        front_buffer_q, front_buffer_d;
  logic        host_issue;

  // A host access may only start when idle, the RAM is not claimed by scan,
  // and no swap is waiting (the back buffer must not change under it).
  always_comb begin
    host_issue = (state_q == ST_IDLE) && host_req && !swap_pending_q && !scan_req;
  end

  always_comb begin
    state_d      = state_q;
    host_ack_d   = 1'b0;
    scan_valid_d = scan_req;
    case (state_q)
      ST_IDLE: begin
        if (host_issue) begin
          state_d    = ST_ACK;
          host_ack_d = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A swap request in the same cycle as frame_end only arms the swap; the
  // exchange waits for the following frame_end.
  always_comb begin
    swap_pending_d = swap_pending_q;
    front_buffer_d = front_buffer_q;
    swap_done_d    = 1'b0;
    if (host_swap && !swap_pending_q) begin
      swap_pending_d = 1'b1;
    end else if (frame_end && swap_pending_q) begin
      swap_pending_d = 1'b0;
      front_buffer_d = ~front_buffer_q;
      swap_done_d    = 1'b1;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = {~front_buffer_q, host_addr};
    ram_wdata = host_wdata;
    if (scan_req) begin
      ram_addr = {front_buffer_q, scan_addr};
    end else if (host_issue) begin
      ram_we = host_we & reset;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      host_ack_q     <= 1'b0;
      scan_valid_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      front_buffer_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      host_ack_q     <= host_ack_d;
      scan_valid_q   <= scan_valid_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      front_buffer_q <= front_buffer_d;
    end
  end

  assign host_ack     = host_ack_q;
  assign host_rdata   = ram_rdata;
  assign scan_valid   = scan_valid_q;
  assign scan_data    = ram_rdata;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;
  assign front_buffer = front_buffer_q;

endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter with a 1-cycle-latency RAM stand-in.
module tb_pixel_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 24;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          frame_end;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          host_swap;
  logic          swap_pending;
  logic          swap_done;
  logic          front_buffer;
  logic [AW:0]   ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:(1<<(AW+1))-1];

  int checks = 0;
  int errors = 0;

  pixel_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_in(clk_in), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid), .scan_data(scan_data),
    .frame_end(frame_end),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .host_swap(host_swap), .swap_pending(swap_pending), .swap_done(swap_done),
    .front_buffer(front_buffer),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; scan_req = 1'b0; scan_addr = '0; frame_end = 1'b0; host_swap = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'd5; host_wdata = 24'hABCDEF;
    settle;
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %0h want 0", host_ack); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL rst_scan_valid got %0h want 0", scan_valid); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %0h want 0", swap_pending); end
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL rst_swap_done got %0h want 0", swap_done); end
    checks++; if (front_buffer !== 1'b0) begin errors++; $display("FAIL rst_front got %0h want 0", front_buffer); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %0h want 0", ram_we); end
    tick;
    reset = 1'b1;
    settle;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_issue_we got %0h want 1", ram_we); end
    checks++; if (ram_addr !== 12'h805) begin errors++; $display("FAIL rst_issue_addr got %0h want 805", ram_addr); end
    reset = 1'b0;
    settle;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %0h want 0", ram_we); end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack got %0h want 0", host_ack); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_hold_we got %0h want 0", ram_we); end
      checks++; if (front_buffer !== 1'b0) begin errors++; $display("FAIL rst_hold_front got %0h want 0", front_buffer); end
    end
    tick;
    reset = 1'b1;
    settle;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_reissue_we got %0h want 1", ram_we); end
    tick;
    host_req = 1'b0;
    settle;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rst_reissue_ack got %0h want 1", host_ack); end
    tick;
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack_once got %0h want 0", host_ack); end
  endtask

  task automatic test_priority;
    logic [AW:0] exp_addr;
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h010; host_wdata = 24'hFF0000;
    scan_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      scan_addr = 11'(i);
      exp_addr = {1'b0, 11'(i)};
      settle;
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL prio_we cyc %0d got %0h want 0", i, ram_we); end
      checks++; if (ram_addr !== exp_addr) begin errors++; $display("FAIL prio_addr cyc %0d got %0h want %0h", i, ram_addr, exp_addr); end
      checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL prio_ack cyc %0d got %0h want 0", i, host_ack); end
      if (i > 0) begin
        checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL prio_scan_valid cyc %0d got %0h want 1", i, scan_valid); end
      end
      tick;
    end
    scan_req = 1'b0;
    settle;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL prio_issue_we got %0h want 1", ram_we); end
    checks++; if (ram_addr !== 12'h810) begin errors++; $display("FAIL prio_issue_addr got %0h want 810", ram_addr); end
    checks++; if (ram_wdata !== 24'hFF0000) begin errors++; $display("FAIL prio_issue_wdata got %0h want ff0000", ram_wdata); end
    tick;
    host_req = 1'b0;
    settle;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL prio_ack got %0h want 1", host_ack); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL prio_scan_idle got %0h want 0", scan_valid); end
    tick;
  endtask

  task automatic test_readback;
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h123; host_wdata = 24'h00FF00;
    settle;
    checks++; if (ram_addr !== 12'h923 || ram_we !== 1'b1) begin errors++; $display("FAIL rb_write got addr %0h we %0h want 923 1", ram_addr, ram_we); end
    tick;
    host_req = 1'b0;
    settle;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rb_write_ack got %0h want 1", host_ack); end
    tick;
    host_swap = 1'b1;
    tick;
    host_swap = 1'b0;
    settle;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL rb_pending got %0h want 1", swap_pending); end
    checks++; if (front_buffer !== 1'b0) begin errors++; $display("FAIL rb_front_early got %0h want 0", front_buffer); end
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    settle;
    checks++; if (front_buffer !== 1'b1) begin errors++; $display("FAIL rb_front got %0h want 1", front_buffer); end
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL rb_swap_done got %0h want 1", swap_done); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL rb_pending_clr got %0h want 0", swap_pending); end
    scan_req = 1'b1; scan_addr = 11'h123;
    settle;
    checks++; if (ram_addr !== 12'h923) begin errors++; $display("FAIL rb_scan_addr got %0h want 923", ram_addr); end
    tick;
    scan_req = 1'b0;
    settle;
    checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL rb_scan_valid got %0h want 1", scan_valid); end
    checks++; if (scan_data !== 24'h00FF00) begin errors++; $display("FAIL rb_scan_data got %0h want 00ff00", scan_data); end
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL rb_swap_done_once got %0h want 0", swap_done); end
    tick;
  endtask

  task automatic test_swap_blocking;
    host_swap = 1'b1;
    tick;
    host_swap = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h123;
    for (int i = 0; i < 3; i++) begin
      settle;
      checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL blk_ack cyc %0d got %0h want 0", i, host_ack); end
      checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL blk_pending cyc %0d got %0h want 1", i, swap_pending); end
      tick;
    end
    frame_end = 1'b1;
    settle;
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL blk_ack_fe got %0h want 0", host_ack); end
    tick;
    frame_end = 1'b0;
    settle;
    checks++; if (front_buffer !== 1'b0) begin errors++; $display("FAIL blk_front got %0h want 0", front_buffer); end
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL blk_swap_done got %0h want 1", swap_done); end
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL blk_ack_early got %0h want 0", host_ack); end
    checks++; if (ram_addr !== 12'h923) begin errors++; $display("FAIL blk_issue_addr got %0h want 923", ram_addr); end
    tick;
    host_req = 1'b0;
    settle;
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL blk_ack got %0h want 1", host_ack); end
    checks++; if (host_rdata !== 24'h00FF00) begin errors++; $display("FAIL blk_rdata got %0h want 00ff00", host_rdata); end
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL blk_swap_done_once got %0h want 0", swap_done); end
    tick;
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL blk_ack_once got %0h want 0", host_ack); end
  endtask

  task automatic test_simultaneous;
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    settle;
    checks++; if (front_buffer !== 1'b0 || swap_done !== 1'b0) begin errors++; $display("FAIL sim_lone_fe got front %0h done %0h want 0 0", front_buffer, swap_done); end
    host_swap = 1'b1; frame_end = 1'b1;
    tick;
    host_swap = 1'b0; frame_end = 1'b0;
    settle;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL sim_pending got %0h want 1", swap_pending); end
    checks++; if (front_buffer !== 1'b0) begin errors++; $display("FAIL sim_no_toggle got %0h want 0", front_buffer); end
    checks++; if (swap_done !== 1'b0) begin errors++; $display("FAIL sim_no_done got %0h want 0", swap_done); end
    host_swap = 1'b1;
    tick;
    host_swap = 1'b0;
    settle;
    checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL sim_repeat_swap got %0h want 1", swap_pending); end
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
    settle;
    checks++; if (front_buffer !== 1'b1) begin errors++; $display("FAIL sim_toggle got %0h want 1", front_buffer); end
    checks++; if (swap_done !== 1'b1) begin errors++; $display("FAIL sim_done got %0h want 1", swap_done); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL sim_pending_clr got %0h want 0", swap_pending); end
    tick;
    checks++; if (swap_done !== 1'b0 || front_buffer !== 1'b1) begin errors++; $display("FAIL sim_after got done %0h front %0h want 0 1", swap_done, front_buffer); end
  endtask

  task automatic test_back_to_back;
    int acks;
    int wes;
    logic [AW:0]   exp_addr;
    logic [DW-1:0] exp_data;
    acks = 0;
    wes = 0;
    host_req = 1'b1; host_we = 1'b1; scan_addr = 11'h123;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        host_addr = 11'(32 + k / 2);
        host_wdata = 24'h0A0000 + 24'(k);
      end
      scan_req = (k % 2 == 1);
      settle;
      if (host_ack === 1'b1) acks++;
      if (ram_we === 1'b1) wes++;
      if (k % 2 == 0) begin
        exp_addr = {1'b0, 11'(32 + k / 2)};
        exp_data = 24'h0A0000 + 24'(k);
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL b2b_we cyc %0d got %0h want 1", k, ram_we); end
        checks++; if (ram_addr !== exp_addr) begin errors++; $display("FAIL b2b_addr cyc %0d got %0h want %0h", k, ram_addr, exp_addr); end
        checks++; if (ram_wdata !== exp_data) begin errors++; $display("FAIL b2b_wdata cyc %0d got %0h want %0h", k, ram_wdata, exp_data); end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack cyc %0d got %0h want 0", k, host_ack); end
        if (k > 0) begin
          checks++; if (scan_valid !== 1'b1 || scan_data !== 24'h00FF00) begin errors++; $display("FAIL b2b_scan cyc %0d got %0h/%0h want 1/00ff00", k, scan_valid, scan_data); end
        end
      end else begin
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL b2b_we cyc %0d got %0h want 0", k, ram_we); end
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack cyc %0d got %0h want 1", k, host_ack); end
        checks++; if (ram_addr !== 12'h923) begin errors++; $display("FAIL b2b_scan_addr cyc %0d got %0h want 923", k, ram_addr); end
      end
      tick;
    end
    host_req = 1'b0; scan_req = 1'b0;
    settle;
    checks++; if (scan_valid !== 1'b1 || scan_data !== 24'h00FF00) begin errors++; $display("FAIL b2b_last_scan got %0h/%0h want 1/00ff00", scan_valid, scan_data); end
    checks++; if (host_ack !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL b2b_quiet got ack %0h we %0h want 0 0", host_ack, ram_we); end
    checks++; if (acks != 4) begin errors++; $display("FAIL b2b_ack_count got %0d want 4", acks); end
    checks++; if (wes != 4) begin errors++; $display("FAIL b2b_we_count got %0d want 4", wes); end
    tick;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h022;
    settle;
    checks++; if (ram_addr !== 12'h022 || ram_we !== 1'b0) begin errors++; $display("FAIL b2b_rd_issue got addr %0h we %0h want 022 0", ram_addr, ram_we); end
    tick;
    host_req = 1'b0;
    settle;
    checks++; if (host_ack !== 1'b1 || host_rdata !== 24'h0A0004) begin errors++; $display("FAIL b2b_rd got ack %0h data %0h want 1 0a0004", host_ack, host_rdata); end
    tick;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_readback();
    test_swap_blocking();
    test_simultaneous();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
